b10_counter: RTL and testbench

Registered N-digit BCD up-counter that holds the running decimal value and feeds each digit, with the increment request as carry-in, into a chain of `b10_halfadder` digit stages. It then captures the chain's result on the next clock edge. It sits directly upstream of the half-adder stages and owns all state they lack:

- the count register,
- wrap detection and the sticky overflow flag,
- parallel load with BCD validation.

---
 rtl/b10_counter_pkg.sv | 14 +
 rtl/b10_halfadder.sv | 26 ++
 rtl/b10_counter.sv | 83 ++++++++
 tb/tb_b10_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/b10_counter_pkg.sv
// b10_counter_pkg
//   Shared constants for the BCD counter and its digit stages.
//   BCD_W    : width of one BCD digit
//   BCD_MAX  : largest legal digit value
//   N_MIN/MAX: legal bounds for the digit-count parameter N
package b10_counter_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    localparam int unsigned N_MIN = 1;
    localparam int unsigned N_MAX = 8;

endpackage

// File: rtl/b10_halfadder.sv
// b10_halfadder
//   One BCD digit stage: adds a single-bit carry-in to a decimal digit.
//   Ports:
//     a    in  BCD_W  digit value, 0..9 (10..15 are don't-care)
//     cin  in  1      carry-in
//     s    out BCD_W  result digit, 0..9
//     cout out 1      carry-out, set when a 9 rolls over to 0
module b10_halfadder
    import b10_counter_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic             cin,
    output logic [BCD_W-1:0] s,
    output logic             cout
);

    always_comb begin
        cout = cin && (a == BCD_MAX);
        if (cout) begin
            s = '0;
        end else begin
            s = a + {{(BCD_W-1){1'b0}}, cin};
        end
    end

endmodule

// File: rtl/b10_counter.sv
// b10_counter
//   Registered N-digit BCD up-counter built on a ripple chain of b10_halfadder
//   stages. Owns the count register, wrap/overflow flags and validated load.
//   Priority per edge: clr > load > inc.
//   Ports:
//     clock    in  1     rising-edge clock
//     reset_   in  1     asynchronous active-low reset
//     inc      in  1     add one this cycle
//     clr      in  1     synchronous clear of count and overflow
//     load     in  1     synchronous parallel load from din
//     din      in  4N    load value, digit i at [4i+3:4i]
//     dout     out 4N    current count (registered)
//     wrap     out 1     one-cycle pulse when count rolls from all-9s to 0
//     ovf      out 1     sticky overflow, cleared by clr or reset
//     load_err out 1     one-cycle pulse when a load is rejected
module b10_counter
    import b10_counter_pkg::*;
#(
    parameter int unsigned N = 4  // legal range N_MIN..N_MAX
) (
    input  logic               clock,
    input  logic               reset_,
    input  logic               inc,
    input  logic               clr,
    input  logic               load,
    input  logic [BCD_W*N-1:0] din,
    output logic [BCD_W*N-1:0] dout,
    output logic               wrap,
    output logic               ovf,
    output logic               load_err
);

    logic [N:0]         carry;
    logic [BCD_W*N-1:0] sum;
    logic [N-1:0]       digit_ok;
    logic               din_ok;

    assign carry[0] = inc;

    for (genvar i = 0; i < N; i++) begin : g_digit
        b10_halfadder u_stage (
            .a    (dout[BCD_W*i +: BCD_W]),
            .cin  (carry[i]),
            .s    (sum[BCD_W*i +: BCD_W]),
            .cout (carry[i+1])
        );

        assign digit_ok[i] = (din[BCD_W*i +: BCD_W] <= BCD_MAX);
    end

    assign din_ok = &digit_ok;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            dout     <= '0;
            wrap     <= 1'b0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            // Pulse flags default low; set only by the event of this cycle.
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                dout <= '0;
                ovf  <= 1'b0;
            end else if (load) begin
                if (din_ok) begin
                    dout <= din;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (inc) begin
                // On wrap every stage rolls to 0, so sum is already all zeros.
                dout <= sum;
                if (carry[N]) begin
                    wrap <= 1'b1;
                    ovf  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_b10_counter.sv
module tb_b10_counter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clock = 1'b0;
    logic         reset_ = 1'b0;
    logic         inc = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic         wrap;
    logic         ovf;
    logic         load_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         clr;
        logic         load;
        logic         inc;
        logic [W-1:0] din;
        logic [W-1:0] dout;
        logic         wrap;
        logic         ovf;
        logic         err;
        string        name;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    b10_counter #(.N(N)) dut (
        .clock    (clock),
        .reset_   (reset_),
        .inc      (inc),
        .clr      (clr),
        .load     (load),
        .din      (din),
        .dout     (dout),
        .wrap     (wrap),
        .ovf      (ovf),
        .load_err (load_err)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  x;
        x = v;
        for (int i = 0; i < int'(N); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic void add(input string nm, input logic c, input logic l, input logic i,
                                input logic [W-1:0] d, input logic [W-1:0] q,
                                input logic wr, input logic ov, input logic er);
        vec_t v;
        v.name = nm; v.clr = c; v.load = l; v.inc = i; v.din = d;
        v.dout = q; v.wrap = wr; v.ovf = ov; v.err = er;
        vecs.push_back(v);
    endfunction

    task automatic check_bit(input string nm, input string fld, input logic got,
                             input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s %s: got %b expected %b", nm, fld, got, want);
        end
    endtask

    task automatic check_out(input string nm, input logic [W-1:0] q, input logic wr,
                             input logic ov, input logic er);
        checks++;
        if (dout !== q) begin
            errors++;
            $display("FAIL %s dout: got %h expected %h", nm, dout, q);
        end
        check_bit(nm, "wrap", wrap, wr);
        check_bit(nm, "ovf", ovf, ov);
        check_bit(nm, "load_err", load_err, er);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clock);
        clr = v.clr; load = v.load; inc = v.inc; din = v.din;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = exp_q.pop_front();
            check_out(e.name, e.dout, e.wrap, e.ovf, e.err);
        end
    endtask

    initial begin
        // Count 12 from reset.
        for (int k = 1; k <= 12; k++) add("count", 0, 0, 1, '0, to_bcd(k), 0, 0, 0);
        add("idle_hold",  0, 0, 0, '0,       16'h0012, 0, 0, 0);
        // Carry ripple through three digits.
        add("ld_0999",    0, 1, 0, 16'h0999, 16'h0999, 0, 0, 0);
        add("ripple",     0, 0, 1, '0,       16'h1000, 0, 0, 0);
        // Wrap and sticky overflow.
        add("ld_9998",    0, 1, 0, 16'h9998, 16'h9998, 0, 0, 0);
        add("inc_9999",   0, 0, 1, '0,       16'h9999, 0, 0, 0);
        add("wrap",       0, 0, 1, '0,       16'h0000, 1, 1, 0);
        add("post_wrap",  0, 0, 1, '0,       16'h0001, 0, 1, 0);
        add("ovf_sticky", 0, 0, 0, '0,       16'h0001, 0, 1, 0);
        add("ld_keep_ov", 0, 1, 0, 16'h0042, 16'h0042, 0, 1, 0);
        add("clr_ovf",    1, 0, 0, '0,       16'h0000, 0, 0, 0);
        // Invalid loads.
        add("ld_0042",    0, 1, 0, 16'h0042, 16'h0042, 0, 0, 0);
        add("ld_12a4",    0, 1, 0, 16'h12A4, 16'h0042, 0, 0, 1);
        add("err_pulse",  0, 0, 0, '0,       16'h0042, 0, 0, 0);
        add("ld_5678",    0, 1, 0, 16'h5678, 16'h5678, 0, 0, 0);
        add("ld_a000",    0, 1, 0, 16'hA000, 16'h5678, 0, 0, 1);
        add("ld_000f",    0, 1, 0, 16'h000F, 16'h5678, 0, 0, 1);
        // Priority.
        add("ld_9999",    0, 1, 0, 16'h9999, 16'h9999, 0, 0, 0);
        add("clr_inc",    1, 0, 1, '0,       16'h0000, 0, 0, 0);
        add("clr_ld",     1, 1, 0, 16'h1111, 16'h0000, 0, 0, 0);
        add("ld_inc",     0, 1, 1, 16'h0100, 16'h0100, 0, 0, 0);
        add("ld_bad_inc", 0, 1, 1, 16'hB000, 16'h0100, 0, 0, 1);
        // Set up for async reset: count 0457 with ovf set.
        add("ld_9999b",   0, 1, 0, 16'h9999, 16'h9999, 0, 0, 0);
        add("wrap2",      0, 0, 1, '0,       16'h0000, 1, 1, 0);
        add("ld_0456",    0, 1, 0, 16'h0456, 16'h0456, 0, 1, 0);
        add("inc_0457",   0, 0, 1, '0,       16'h0457, 0, 1, 0);

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_out("in_reset", '0, 0, 0, 0);
        @(negedge clock);
        reset_ = 1'b1;
        @(posedge clock);
        #1;
        check_out("after_reset", '0, 0, 0, 0);

        foreach (vecs[k]) apply(vecs[k]);

        // Async reset between edges.
        @(negedge clock);
        inc = 1'b0; clr = 1'b0; load = 1'b0; din = '0;
        #2;
        reset_ = 1'b0;
        #1;
        check_out("async_reset", '0, 0, 0, 0);
        @(posedge clock);
        #1;
        check_out("reset_held", '0, 0, 0, 0);
        @(negedge clock);
        reset_ = 1'b1;
        begin
            vec_t v;
            v.name = "resume"; v.clr = 0; v.load = 0; v.inc = 1; v.din = '0;
            v.dout = 16'h0001; v.wrap = 0; v.ovf = 0; v.err = 0;
            apply(v);
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
